time_bcd_formatter: RTL and testbench

//  Downstream of the countdown timer core. Converts its binary seconds count (0..5999) into four BCD digits MM:SS
//  for the VGA character renderer, using a fixed-latency sequential divide-by-60 plus double-dabble.
//  Re-converts automatically whenever the incoming time or timer state changes, and re-times the timer state so it

---
 rtl/time_bcd_formatter.sv | 144 ++++++++++++++
 tb/tb_time_bcd_formatter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/time_bcd_formatter.sv
// Binary seconds (0..5999) to MM:SS BCD digits for the character renderer.
// Fixed 16-clock latency: 7-step restoring divide by 60, then 7-step double-dabble.
module time_bcd_formatter #(
    parameter int IN_W        = 16,
    parameter int MAX_SECONDS = 5999
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] time_in,
    input  logic [1:0]      estado_in,
    output logic [3:0]      min_tens,
    output logic [3:0]      min_units,
    output logic [3:0]      sec_tens,
    output logic [3:0]      sec_units,
    output logic [1:0]      estado_out,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        BCD  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [IN_W-1:0] MAX_IN = IN_W'(MAX_SECONDS);
    localparam logic [12:0]     MAX13  = 13'(MAX_SECONDS);

    state_e          state_q;
    logic [2:0]      cnt_q;
    logic [IN_W-1:0] last_time_q;
    logic [1:0]      last_est_q;
    logic [12:0]     work_q;
    logic [1:0]      est_work_q;
    logic [6:0]      quo_q;
    logic [14:0]     mshift_q;
    logic [14:0]     sshift_q;
    logic [3:0]      min_tens_q;
    logic [3:0]      min_units_q;
    logic [3:0]      sec_tens_q;
    logic [3:0]      sec_units_q;
    logic [1:0]      estado_q;
    logic            done_q;

    logic            trigger_d;
    logic [12:0]     clamp_d;
    logic [13:0]     trial_d;
    logic [12:0]     work_d;
    logic [6:0]      quo_d;

    // One double-dabble step: BCD pair in [14:7], binary in [6:0].
    function automatic logic [14:0] dd_shift(input logic [14:0] s);
        logic [14:0] a;
        a = s;
        if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
        if (a[10:7] >= 4'd5)  a[10:7]  = a[10:7] + 4'd3;
        return {a[13:0], 1'b0};
    endfunction

    always_comb begin
        trigger_d = (time_in != last_time_q) || (estado_in != last_est_q);
        clamp_d   = (time_in > MAX_IN) ? MAX13 : time_in[12:0];
        // Quotient bit cnt_q weighs 60 << cnt_q; no borrow means the bit is 1.
        trial_d   = {1'b0, work_q} - (14'd60 << cnt_q);
        work_d    = trial_d[13] ? work_q : trial_d[12:0];
        quo_d     = {quo_q[5:0], ~trial_d[13]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            last_time_q <= '0;
            last_est_q  <= 2'd1;
            work_q      <= 13'd0;
            est_work_q  <= 2'd1;
            quo_q       <= 7'd0;
            mshift_q    <= 15'd0;
            sshift_q    <= 15'd0;
            min_tens_q  <= 4'd0;
            min_units_q <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_units_q <= 4'd0;
            estado_q    <= 2'd1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (trigger_d) begin
                        last_time_q <= time_in;
                        last_est_q  <= estado_in;
                        work_q      <= clamp_d;
                        est_work_q  <= estado_in;
                        quo_q       <= 7'd0;
                        cnt_q       <= 3'd6;
                        state_q     <= DIV;
                    end
                end
                DIV: begin
                    work_q <= work_d;
                    quo_q  <= quo_d;
                    if (cnt_q == 3'd0) begin
                        mshift_q <= {8'd0, quo_d};
                        sshift_q <= {8'd0, work_d[6:0]};
                        cnt_q    <= 3'd6;
                        state_q  <= BCD;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                BCD: begin
                    mshift_q <= dd_shift(mshift_q);
                    sshift_q <= dd_shift(sshift_q);
                    if (cnt_q == 3'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    min_tens_q  <= mshift_q[14:11];
                    min_units_q <= mshift_q[10:7];
                    sec_tens_q  <= sshift_q[14:11];
                    sec_units_q <= sshift_q[10:7];
                    estado_q    <= est_work_q;
                    done_q      <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign min_tens   = min_tens_q;
    assign min_units  = min_units_q;
    assign sec_tens   = sec_tens_q;
    assign sec_units  = sec_units_q;
    assign estado_out = estado_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_time_bcd_formatter.sv
// Directed bench for time_bcd_formatter: vector table plus
// mid-flight change and mid-conversion reset sequences.
module tb_time_bcd_formatter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] time_in = 16'd0;
    logic [1:0]  estado_in = 2'd1;
    logic [3:0]  min_tens, min_units, sec_tens, sec_units;
    logic [1:0]  estado_out;
    logic        busy, done;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    time_bcd_formatter #(.IN_W(16), .MAX_SECONDS(5999)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_in    (time_in),
        .estado_in  (estado_in),
        .min_tens   (min_tens),
        .min_units  (min_units),
        .sec_tens   (sec_tens),
        .sec_units  (sec_units),
        .estado_out (estado_out),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [15:0] t;
        logic [1:0]  e;
        logic [15:0] dig;
        logic [1:0]  eo;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [15:0] digits();
        return {min_tens, min_units, sec_tens, sec_units};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a posedge; the next posedge is the trigger edge.
    task automatic convert(input logic [15:0] t, input logic [1:0] e,
                           input logic [15:0] dig, input logic [1:0] eo);
        int lat;
        lat = 0;
        time_in   = t;
        estado_in = e;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) check("busy_rise", {31'd0, busy}, 32'd1);
            if (done) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, 16);
        check("digits", {16'd0, digits()}, {16'd0, dig});
        check("estado_out", {30'd0, estado_out}, {30'd0, eo});
        check("busy_at_done", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int nbusy;

        vecs[0] = '{16'd125,   2'd1, 16'h0205, 2'd1};
        vecs[1] = '{16'd5999,  2'd1, 16'h9959, 2'd1};
        vecs[2] = '{16'd6000,  2'd1, 16'h9959, 2'd1};
        vecs[3] = '{16'd8191,  2'd1, 16'h9959, 2'd1};
        vecs[4] = '{16'd65535, 2'd1, 16'h9959, 2'd1};
        vecs[5] = '{16'd60,    2'd1, 16'h0100, 2'd1};
        vecs[6] = '{16'd59,    2'd1, 16'h0059, 2'd1};
        vecs[7] = '{16'd59,    2'd2, 16'h0059, 2'd2};
        vecs[8] = '{16'd0,     2'd0, 16'h0000, 2'd0};
        vecs[9] = '{16'd1234,  2'd2, 16'h2034, 2'd2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", {16'd0, digits()}, 32'd0);
        check("rst_estado", {30'd0, estado_out}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        check("idle_no_done", ndone, 0);
        check("idle_no_busy", nbusy, 0);
        check("idle_digits", {16'd0, digits()}, 32'd0);

        for (int v = 0; v < 10; v++)
            convert(vecs[v].t, vecs[v].e, vecs[v].dig, vecs[v].eo);

        // Mid-flight changes: 299 must be skipped, 298 follows 300.
        time_in   = 16'd300;
        estado_in = 2'd1;
        ndone = 0;
        for (int i = 0; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) time_in = 16'd299;
            if (i == 9) time_in = 16'd298;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    check("mf_first_edge", i, 15);
                    check("mf_first_dig", {16'd0, digits()}, 32'h0500);
                end else if (ndone == 2) begin
                    check("mf_second_edge", i, 31);
                    check("mf_second_dig", {16'd0, digits()}, 32'h0458);
                end
            end
        end
        check("mf_done_count", ndone, 2);

        convert(16'd298, 2'd2, 16'h0458, 2'd2);

        // Reset asserted on E8 of a conversion.
        time_in   = 16'd1234;
        estado_in = 2'd2;
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk);
            #1;
        end
        check("mr_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_digits", {16'd0, digits()}, 32'd0);
        check("mr_estado", {30'd0, estado_out}, 32'd1);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_done", {31'd0, done}, 32'd0);
        time_in   = 16'd0;
        estado_in = 2'd1;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        rst_n = 1'b1;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        check("mr_no_done", ndone, 0);
        check("mr_no_busy", nbusy, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
